frame_update_scheduler: RTL and testbench
=========================================

Name: frame_update_scheduler

Overview:
- Frame-rate sequencer between the VGA timing generator and the game-logic blocks (Pacman mover, ghost mover, bean map).
- On every FRAME_DIV-th vertical sync, issues one request/acknowledge step to each logic block in a fixed order.
- Then latches the new sprite coordinates into the registers that feed the display pixel datapath.
- Coordinates seen by the display therefore change only during vertical sync, so sprites never tear mid-frame.

Parameters:
- FRAME_DIV, 4, number of vsync pulses per game step (legal range 1..255).
- ACK_TIMEOUT, 1024, clock cycles to wait for an ack before abandoning that phase.
- SPRITE, 32, sprite edge in pixels; used by the collision check.

Ports:
- clk  in  1  system clock
- clrn  in  1  asynchronous active-low reset
- vs  in  1  vertical sync from the VGA controller, active-low pulse, asynchronous to game logic
- pac_x_in  in  10  Pacman X from the mover
- pac_y_in  in  9  Pacman Y from the mover
- ghost_x_in  in  10  ghost X from the mover
- ghost_y_in  in  9  ghost Y from the mover
- pac_req  out  1  step request to the Pacman mover
- pac_ack  in  1  step done
- ghost_req  out  1  step request to the ghost mover
- ghost_ack  in  1  step done
- bean_req  out  1  eat-check request to the bean map
- bean_ack  in  1  check done
- pac_x  out  10  latched Pacman X to the display
- pac_y  out  9  latched Pacman Y to the display
- ghost_x  out  10  latched ghost X to the display
- ghost_y  out  9  latched ghost Y to the display
- busy  out  1  high while a step sequence is in progress
- timeout_err  out  1  sticky: some phase timed out
- overrun  out  1  sticky: a frame tick arrived while busy
- collide  out  1  one-cycle collision pulse (optional feature)

Behaviour:
- Reset (clrn=0, asynchronous): every output is 0, FSM is in IDLE, and all counters are 0. Asserting reset mid-sequence aborts it immediately and drops every req.
- vs passes through a 2-flop synchronizer. A frame tick is a 1-cycle pulse on a synchronized 1->0 edge of vs. Tick latency is 3 clk after the vs edge.
- div_cnt (8 bit) increments on each tick.
  - When div_cnt == FRAME_DIV-1 and the FSM is in IDLE: div_cnt wraps to 0 and the FSM enters PAC.
  - When FRAME_DIV=1, every tick starts a step.
- FSM states: IDLE -> PAC -> GHOST -> BEAN -> LATCH -> IDLE.
- PAC, GHOST and BEAN each behave as follows:
  - The state's req is high for every cycle spent in the state.
  - The FSM advances on the first cycle its ack is sampled high, and req drops in the same clock edge.
  - An ack already high on state entry is accepted on the first cycle (minimum 1 cycle per phase).
  - Acks for other phases are ignored.
- Timeout: wait_cnt clears on entry to each phase and increments every cycle in the phase.
  - At wait_cnt == ACK_TIMEOUT-1 without an ack: req drops, timeout_err sets, and the FSM advances to the next phase.
  - timeout_err stays set until reset.
- LATCH lasts 1 cycle: the *_in coordinates are registered into pac_x, pac_y, ghost_x and ghost_y. The outputs are valid the cycle after LATCH. Outside LATCH the outputs hold.
- busy = (state != IDLE).
- A tick arriving while busy is dropped: div_cnt does not increment and overrun sets (sticky until reset).
- At most one req is high in any cycle.

Optional Feature:
- Macro COLLIDE_CHECK_EN.
- Defined: in the cycle after LATCH, compute the collision from the newly latched registers.
  - Condition: |pac_x-ghost_x| < SPRITE and |pac_y-ghost_y| < SPRITE, using unsigned absolute differences, 10-bit for X and 9-bit for Y.
  - If true, collide pulses high for exactly 1 cycle, in the second cycle after LATCH.
- Undefined: collide is tied to 0 and no comparator logic exists.

Test Plan:
- Reset, FRAME_DIV=4, ack each req 2 cycles after it rises; drive 8 vs pulses -> exactly 2 sequences, each with pac_req, then ghost_req, then bean_req, never overlapping. pac_x updates only after LATCH.
- pac_x_in=100, pac_y_in=50 changed mid-frame with no tick -> pac_x and pac_y hold their old values until the next LATCH, then read 100 and 50.
- ghost_ack never asserted, ACK_TIMEOUT=16 -> ghost_req high for exactly 16 cycles, timeout_err=1, bean_req follows, LATCH still occurs.
- Hold all acks low, send a second qualifying tick while busy -> overrun=1, and div_cnt shows no extra step after recovery.
- Pull clrn low while bean_req=1 -> all reqs and outputs 0 asynchronously, busy=0, and the next sequence restarts at PAC.
- COLLIDE_CHECK_EN defined, latched pac (100,50) and ghost (120,70) -> collide pulses 1 cycle. With ghost (132,50) -> no pulse.

Source files
------------

// File: rtl/frame_update_scheduler.sv
// frame_update_scheduler
//   Frame-rate sequencer between the VGA timing generator and the game logic.
//   Every FRAME_DIV-th vertical sync it runs one request/acknowledge step on
//   the Pacman mover, then the ghost mover, then the bean map, and finally
//   latches the sprite coordinates that feed the display datapath. Display
//   coordinates therefore only change during vertical sync.
//
// Parameters
//   FRAME_DIV   vsync pulses per game step (1..255)
//   ACK_TIMEOUT cycles to wait for an ack before abandoning a phase
//   SPRITE      sprite edge in pixels, used by the collision check
//
// Ports
//   clk, clrn                       clock, asynchronous active-low reset
//   vs                              vertical sync, active-low, asynchronous
//   pac_x_in/pac_y_in               Pacman coordinates from the mover
//   ghost_x_in/ghost_y_in           ghost coordinates from the mover
//   pac_req/ack, ghost_req/ack,
//   bean_req/ack                    per-block step handshakes
//   pac_x/pac_y, ghost_x/ghost_y    latched coordinates to the display
//   busy                            step sequence in progress
//   timeout_err                     sticky: some phase timed out
//   overrun                         sticky: frame tick arrived while busy
//   collide                         one-cycle collision pulse
//
// Build option
//   COLLIDE_CHECK_EN  when defined, a collision comparator runs on the freshly
//                     latched coordinates; otherwise collide is tied low.
module frame_update_scheduler #(
  parameter int FRAME_DIV   = 4,
  parameter int ACK_TIMEOUT = 1024,
  parameter int SPRITE      = 32
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       vs,
  input  logic [9:0] pac_x_in,
  input  logic [8:0] pac_y_in,
  input  logic [9:0] ghost_x_in,
  input  logic [8:0] ghost_y_in,
  output logic       pac_req,
  input  logic       pac_ack,
  output logic       ghost_req,
  input  logic       ghost_ack,
  output logic       bean_req,
  input  logic       bean_ack,
  output logic [9:0] pac_x,
  output logic [8:0] pac_y,
  output logic [9:0] ghost_x,
  output logic [8:0] ghost_y,
  output logic       busy,
  output logic       timeout_err,
  output logic       overrun,
  output logic       collide
);

  localparam int WW = $clog2(ACK_TIMEOUT + 1);

  if (FRAME_DIV < 1 || FRAME_DIV > 255) begin : g_bad_div
    $error("FRAME_DIV out of range 1..255");
  end
  if (SPRITE < 1 || SPRITE > 511) begin : g_bad_sprite
    $error("SPRITE out of range 1..511");
  end

  typedef enum logic [2:0] {IDLE, PAC, GHOST, BEAN, LATCH} state_t;

  state_t          state, next;
  logic            vs_s1, vs_s2, vs_s3, tick;
  logic [7:0]      div_cnt;
  logic [WW-1:0]   wait_cnt;
  logic            start, in_phase, expired, phase_ack;

  // Two-flop synchronizer plus one history flop; the registered falling-edge
  // detect gives a tick three clocks after vs drops.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      vs_s1 <= 1'b0;
      vs_s2 <= 1'b0;
      vs_s3 <= 1'b0;
      tick  <= 1'b0;
    end else begin
      vs_s1 <= vs;
      vs_s2 <= vs_s1;
      vs_s3 <= vs_s2;
      tick  <= vs_s3 & ~vs_s2;
    end
  end

  assign start    = tick && (state == IDLE) && (div_cnt == 8'(FRAME_DIV - 1));
  assign in_phase = (state == PAC) || (state == GHOST) || (state == BEAN);
  assign expired  = (wait_cnt == WW'(ACK_TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= next;
  end

  // Next-state logic; only the current phase's ack is looked at
  always_comb begin
    next      = state;
    phase_ack = 1'b0;
    case (state)
      IDLE:  if (start) next = PAC;
      PAC:   begin
               phase_ack = pac_ack;
               if (pac_ack || expired) next = GHOST;
             end
      GHOST: begin
               phase_ack = ghost_ack;
               if (ghost_ack || expired) next = BEAN;
             end
      BEAN:  begin
               phase_ack = bean_ack;
               if (bean_ack || expired) next = LATCH;
             end
      LATCH: next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Outputs decoded from state: at most one req can be high
  always_comb begin
    pac_req   = (state == PAC);
    ghost_req = (state == GHOST);
    bean_req  = (state == BEAN);
    busy      = (state != IDLE);
  end

  // Frame divider, phase watchdog and sticky error flags. Ticks seen while
  // busy are dropped without advancing the divider.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      div_cnt     <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (tick) begin
        if (state == IDLE) div_cnt <= start ? '0 : div_cnt + 8'd1;
        else               overrun <= 1'b1;
      end
      if (next != state)  wait_cnt <= '0;
      else if (in_phase)  wait_cnt <= wait_cnt + WW'(1);
      if (in_phase && !phase_ack && expired) timeout_err <= 1'b1;
    end
  end

  // Display coordinates only move in LATCH
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pac_x   <= '0;
      pac_y   <= '0;
      ghost_x <= '0;
      ghost_y <= '0;
    end else if (state == LATCH) begin
      pac_x   <= pac_x_in;
      pac_y   <= pac_y_in;
      ghost_x <= ghost_x_in;
      ghost_y <= ghost_y_in;
    end
  end

`ifdef COLLIDE_CHECK_EN
  logic       latched_d;
  logic [9:0] dx;
  logic [8:0] dy;

  always_comb begin
    dx = (pac_x >= ghost_x) ? pac_x - ghost_x : ghost_x - pac_x;
    dy = (pac_y >= ghost_y) ? pac_y - ghost_y : ghost_y - pac_y;
  end

  // Compare on the cycle after LATCH so the new registers are used; the
  // pulse appears two cycles after LATCH.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      latched_d <= 1'b0;
      collide   <= 1'b0;
    end else begin
      latched_d <= (state == LATCH);
      collide   <= latched_d && (dx < 10'(SPRITE)) && (dy < 9'(SPRITE));
    end
  end
`else
  assign collide = 1'b0;
`endif

endmodule

// File: tb/tb_frame_update_scheduler.sv
module tb_frame_update_scheduler;

  localparam int FRAME_DIV   = 4;
  localparam int ACK_TIMEOUT = 16;
  localparam int SPRITE      = 32;
`ifdef COLLIDE_CHECK_EN
  localparam bit COL_ON = 1'b1;
`else
  localparam bit COL_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       vs = 1'b1;
  logic [9:0] pac_x_in = '0, ghost_x_in = '0;
  logic [8:0] pac_y_in = '0, ghost_y_in = '0;
  logic       pac_ack = 1'b0, ghost_ack = 1'b0, bean_ack = 1'b0;
  logic       pac_req, ghost_req, bean_req, busy, timeout_err, overrun, collide;
  logic [9:0] pac_x, ghost_x;
  logic [8:0] pac_y, ghost_y;

  always #5 clk = ~clk;

  frame_update_scheduler #(
    .FRAME_DIV  (FRAME_DIV),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .SPRITE     (SPRITE)
  ) dut (
    .clk(clk), .clrn(clrn), .vs(vs),
    .pac_x_in(pac_x_in), .pac_y_in(pac_y_in),
    .ghost_x_in(ghost_x_in), .ghost_y_in(ghost_y_in),
    .pac_req(pac_req), .pac_ack(pac_ack),
    .ghost_req(ghost_req), .ghost_ack(ghost_ack),
    .bean_req(bean_req), .bean_ack(bean_ack),
    .pac_x(pac_x), .pac_y(pac_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
    .busy(busy), .timeout_err(timeout_err), .overrun(overrun), .collide(collide)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard entry: what the display registers must read after a step
  typedef struct {
    int unsigned px, py, gx, gy, to;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  // Test vector: coordinates, ghost ack behaviour, expected observations
  typedef struct {
    logic [9:0]  px;
    logic [8:0]  py;
    logic [9:0]  gx;
    logic [8:0]  gy;
    bit          ghost_ack_on;
    int unsigned ghost_len;
    bit          exp_to;
    bit          col;
  } vec_t;
  vec_t vecs[5];

  // Ack responder: each enabled block answers two cycles after its req rises
  bit pac_en = 1'b1, ghost_en = 1'b1, bean_en = 1'b1;
  int unsigned pc = 0, gc = 0, bc = 0;
  always @(negedge clk) begin
    pc = pac_req   ? pc + 1 : 0;
    gc = ghost_req ? gc + 1 : 0;
    bc = bean_req  ? bc + 1 : 0;
    pac_ack   = pac_en   && pac_req   && pc >= 2;
    ghost_ack = ghost_en && ghost_req && gc >= 2;
    bean_ack  = bean_en  && bean_req  && bc >= 2;
  end

  // Monitor: phase order, one-hot reqs, ghost req width, collide cycles,
  // and scoreboard pop at the end of every step
  int unsigned seq_cnt = 0, pops = 0, col_cycles = 0;
  int unsigned ghost_run = 0, ghost_len = 0, onehot_viol = 0, exp_next = 0;
  bit          busy_q = 0, pq = 0, gq = 0, bq = 0;
  logic [9:0]  shown_px = '0;
  logic [8:0]  shown_py = '0;

  always @(negedge clk) begin
    if (!clrn) begin
      busy_q = 0; pq = 0; gq = 0; bq = 0; ghost_run = 0;
    end else begin
      if (int'(pac_req) + int'(ghost_req) + int'(bean_req) > 1) onehot_viol++;
      if (pac_req && !pq) begin
        check("req_order_pac", 0, exp_next);
        exp_next = 1;
        seq_cnt++;
      end
      if (ghost_req && !gq) begin
        check("req_order_ghost", 1, exp_next);
        exp_next = 2;
      end
      if (bean_req && !bq) begin
        check("req_order_bean", 2, exp_next);
        exp_next = 0;
        check("pac_x_held_mid_step", pac_x, shown_px);
        check("pac_y_held_mid_step", pac_y, shown_py);
      end
      if (ghost_req) ghost_run++;
      else if (gq) begin
        ghost_len = ghost_run;
        ghost_run = 0;
      end
      if (collide) col_cycles++;
      if (busy_q && !busy) begin
        pops++;
        if (sb.size() == 0) check("unexpected_step", 1, 0);
        else begin
          e = sb.pop_front();
          check("pac_x",       pac_x,       e.px);
          check("pac_y",       pac_y,       e.py);
          check("ghost_x",     ghost_x,     e.gx);
          check("ghost_y",     ghost_y,     e.gy);
          check("timeout_err", timeout_err, e.to);
          shown_px = 10'(e.px);
          shown_py = 9'(e.py);
        end
      end
      pq = pac_req; gq = ghost_req; bq = bean_req; busy_q = busy;
    end
  end

  task automatic vs_pulse();
    @(negedge clk);
    vs = 1'b0;
    repeat (4) @(negedge clk);
    vs = 1'b1;
    repeat (36) @(negedge clk);
  endtask

  task automatic wait_pop(input int unsigned p0);
    int unsigned n = 0;
    while (pops == p0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("step_completed", int'(pops != p0), 1);
  endtask

  task automatic do_step(input vec_t v);
    int unsigned s0, p0, c0;
    pac_x_in = v.px; pac_y_in = v.py; ghost_x_in = v.gx; ghost_y_in = v.gy;
    pac_en = 1'b1; ghost_en = v.ghost_ack_on; bean_en = 1'b1;
    s0 = seq_cnt; p0 = pops; c0 = col_cycles;
    sb.push_back('{v.px, v.py, v.gx, v.gy, v.exp_to});
    repeat (FRAME_DIV - 1) vs_pulse();
    check("no_early_step", seq_cnt, s0);
    vs_pulse();
    wait_pop(p0);
    repeat (4) @(negedge clk);
    check("one_step", seq_cnt, s0 + 1);
    check("ghost_req_len", ghost_len, v.ghost_len);
    check("collide_cycles", col_cycles - c0, int'(v.col & COL_ON));
    ghost_en = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned s0, p0;
    vec_t v;
    vecs[0] = '{10'd100, 9'd50,  10'd120,  9'd70,  1'b1, 2,  1'b0, 1'b1};
    vecs[1] = '{10'd100, 9'd50,  10'd132,  9'd50,  1'b1, 2,  1'b0, 1'b0};
    vecs[2] = '{10'd200, 9'd100, 10'd180,  9'd131, 1'b1, 2,  1'b0, 1'b1};
    vecs[3] = '{10'd0,   9'd0,   10'd1023, 9'd0,   1'b1, 2,  1'b0, 1'b0};
    vecs[4] = '{10'd300, 9'd200, 10'd50,   9'd50,  1'b0, 16, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_reqs", {pac_req, ghost_req, bean_req}, 0);
    check("rst_pac_x", pac_x, 0);
    check("rst_flags", {timeout_err, overrun, collide}, 0);
    clrn = 1'b1;
    repeat (5) @(negedge clk);

    // Table-driven steps: normal handshakes, collide boundaries, ghost timeout
    for (int i = 0; i < 5; i++) do_step(vecs[i]);
    check("overrun_clear_so_far", overrun, 0);

    // Mid-frame coordinate change without a step must not reach the display
    pac_x_in = 10'd100; pac_y_in = 9'd50;
    repeat (60) @(negedge clk);
    check("hold_pac_x", pac_x, 300);
    check("hold_pac_y", pac_y, 200);
    v = '{10'd100, 9'd50, 10'd50, 9'd50, 1'b1, 2, 1'b1, 1'b0};
    do_step(v);

    // All acks low: long step, second tick lands while busy
    pac_en = 1'b0; ghost_en = 1'b0; bean_en = 1'b0;
    sb.push_back('{100, 50, 50, 50, 1});
    s0 = seq_cnt; p0 = pops;
    repeat (FRAME_DIV) vs_pulse();
    check("busy_during_long_step", busy, 1);
    check("overrun_before_drop", overrun, 0);
    vs_pulse();
    wait_pop(p0);
    check("overrun_set", overrun, 1);
    check("one_step_long", seq_cnt, s0 + 1);
    check("ghost_req_len_timeout", ghost_len, 16);
    // Dropped tick must not count: next step needs a full FRAME_DIV pulses
    v = '{10'd150, 9'd60, 10'd400, 9'd300, 1'b1, 2, 1'b1, 1'b0};
    do_step(v);

    // Asynchronous reset while bean_req is high
    pac_en = 1'b1; ghost_en = 1'b1; bean_en = 1'b1;
    pac_x_in = 10'd500; pac_y_in = 9'd400;
    repeat (FRAME_DIV - 1) vs_pulse();
    @(negedge clk);
    vs = 1'b0;
    for (int n = 0; n < 100 && !bean_req; n++) @(negedge clk);
    check("bean_req_seen", bean_req, 1);
    #2 clrn = 1'b0;
    #1;
    check("arst_reqs", {pac_req, ghost_req, bean_req}, 0);
    check("arst_busy", busy, 0);
    check("arst_pac_x", pac_x, 0);
    check("arst_ghost_y", ghost_y, 0);
    check("arst_flags", {timeout_err, overrun, collide}, 0);
    sb.delete();
    shown_px = '0; shown_py = '0;
    vs = 1'b1;
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    repeat (5) @(negedge clk);
    v = '{10'd60, 9'd40, 10'd80, 9'd60, 1'b1, 2, 1'b0, 1'b1};
    do_step(v);

    check("onehot_violations", onehot_viol, 0);
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
